// File: rtl/fir_coeff_loader_if.sv
// fir_coeff_loader_if
//   Bundles the software-register input, the frame marker and the FIR-facing
//   coefficient outputs of fir_coeff_loader.
//   Signals:
//     reg_data       32  software word, [31:16] = b4, [15:0] = b5 (signed)
//     frame_sync      1  single-cycle channelizer frame-start pulse
//     coeff_b4       16  active b4 coefficient
//     coeff_b5       16  active b5 coefficient
//     coeff_update    1  one-cycle pulse after the active coefficients change
//     update_pending  1  a new word is settling or waiting for a frame edge
//     update_count   16  commits since reset (wraps)
//   Modports:
//     master  drives reg_data/frame_sync, observes the coefficient side
//     slave   the loader itself
interface fir_coeff_loader_if;
    logic [31:0] reg_data;
    logic        frame_sync;
    logic [15:0] coeff_b4;
    logic [15:0] coeff_b5;
    logic        coeff_update;
    logic        update_pending;
    logic [15:0] update_count;

    modport master (
        output reg_data,
        output frame_sync,
        input  coeff_b4,
        input  coeff_b5,
        input  coeff_update,
        input  update_pending,
        input  update_count
    );

    modport slave (
        input  reg_data,
        input  frame_sync,
        output coeff_b4,
        output coeff_b5,
        output coeff_update,
        output update_pending,
        output update_count
    );
endinterface

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader
//   Takes the packed (b4, b5) coefficient word written by software, waits
//   until it has been stable for STABLE_CYCLES consecutive cycles, and then
//   commits it to the FIR tap inputs. Torn or transient writes never reach
//   the filter, and a write that software reverts before it settles produces
//   no commit.
//
//   Optional feature macro: FIR_COEFF_FRAME_ALIGN_EN
//     defined   : a settled word waits in PENDING and commits on the next
//                 frame_sync pulse
//     undefined : a settled word commits immediately; frame_sync is ignored
//
//   Ports:
//     user_clk    in   sole clock, rising edge
//     user_rst_n  in   asynchronous active-low reset
//     bus         slave modport of fir_coeff_loader_if (reg_data, frame_sync,
//                 coeff_b4, coeff_b5, coeff_update, update_pending,
//                 update_count)
module fir_coeff_loader #(
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter logic [15:0] COEFF_RESET_B4 = 16'h0000,
    parameter logic [15:0] COEFF_RESET_B5 = 16'h0000
) (
    input  logic               user_clk,
    input  logic               user_rst_n,
    fir_coeff_loader_if.slave  bus
);

    localparam logic [31:0] RESET_WORD = {COEFF_RESET_B4, COEFF_RESET_B5};
    localparam logic [15:0] LAST_CNT   = 16'(STABLE_CYCLES - 1);

`ifdef FIR_COEFF_FRAME_ALIGN_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PENDING = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;
`endif

    state_t      state_reg;
    logic [31:0] reg_q_reg;          // re-registered software word
    logic [31:0] cand_reg;           // word currently being qualified
    logic [31:0] active_reg;         // word driven to the FIR
    logic [15:0] cnt_reg;            // settle counter
    logic        coeff_update_reg;
    logic        update_pending_reg;
    logic [15:0] update_count_reg;

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_reg          <= IDLE;
            // reg_q starts equal to active so reset itself is not seen as a write
            reg_q_reg          <= RESET_WORD;
            cand_reg           <= RESET_WORD;
            active_reg         <= RESET_WORD;
            cnt_reg            <= 16'd0;
            coeff_update_reg   <= 1'b0;
            update_pending_reg <= 1'b0;
            update_count_reg   <= 16'd0;
        end else begin
            reg_q_reg        <= bus.reg_data;
            coeff_update_reg <= 1'b0;
            update_count_reg <= update_count_reg;

            case (state_reg)
                IDLE: begin
                    if (reg_q_reg != active_reg) begin
                        cand_reg           <= reg_q_reg;
                        cnt_reg            <= 16'd0;
                        state_reg          <= SETTLE;
                        update_pending_reg <= 1'b1;
                    end
                end

                SETTLE: begin
                    if (reg_q_reg != cand_reg) begin
                        // word moved again: restart qualification on the new value
                        cand_reg <= reg_q_reg;
                        cnt_reg  <= 16'd0;
                    end else if (cnt_reg == LAST_CNT) begin
                        if (cand_reg == active_reg) begin
                            // software reverted to the active word; nothing to do
                            state_reg          <= IDLE;
                            update_pending_reg <= 1'b0;
                        end else begin
`ifdef FIR_COEFF_FRAME_ALIGN_EN
                            // a frame_sync on this same edge is deliberately not used
                            state_reg <= PENDING;
`else
                            active_reg         <= cand_reg;
                            coeff_update_reg   <= 1'b1;
                            update_count_reg   <= update_count_reg + 16'd1;
                            state_reg          <= IDLE;
                            update_pending_reg <= 1'b0;
`endif
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end

`ifdef FIR_COEFF_FRAME_ALIGN_EN
                PENDING: begin
                    // a change beats a simultaneous frame_sync
                    if (reg_q_reg != cand_reg) begin
                        cand_reg  <= reg_q_reg;
                        cnt_reg   <= 16'd0;
                        state_reg <= SETTLE;
                    end else if (bus.frame_sync) begin
                        active_reg         <= cand_reg;
                        coeff_update_reg   <= 1'b1;
                        update_count_reg   <= update_count_reg + 16'd1;
                        state_reg          <= IDLE;
                        update_pending_reg <= 1'b0;
                    end
                end
`endif

                default: begin
                    state_reg          <= IDLE;
                    update_pending_reg <= 1'b0;
                end
            endcase
        end
    end

`ifndef FIR_COEFF_FRAME_ALIGN_EN
    // frame_sync has no function without frame alignment; the port stays
    logic unused_frame_sync;
    assign unused_frame_sync = bus.frame_sync;
`endif

    assign bus.coeff_b4       = active_reg[31:16];
    assign bus.coeff_b5       = active_reg[15:0];
    assign bus.coeff_update   = coeff_update_reg;
    assign bus.update_pending = update_pending_reg;
    assign bus.update_count   = update_count_reg;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb_fir_coeff_loader
//   Scoreboard bench for fir_coeff_loader with STABLE_CYCLES = 4 and reset
//   coefficients 0x0100 / 0xFF00. Follows FIR_COEFF_FRAME_ALIGN_EN in the
//   same way as the design.
//   The reference model reasons about runs of an unchanged re-registered
//   word: a run of value v that differs from the active word commits once it
//   is STABLE_CYCLES edges old (immediately, or on a later frame_sync edge
//   when frame alignment is enabled).
module tb_fir_coeff_loader;

    localparam int          S   = 4;
    localparam logic [15:0] RB4 = 16'h0100;
    localparam logic [15:0] RB5 = 16'hFF00;
    localparam logic [31:0] RW  = {RB4, RB5};

    logic user_clk   = 1'b0;
    logic user_rst_n = 1'b0;

    fir_coeff_loader_if bus ();

    fir_coeff_loader #(
        .STABLE_CYCLES (S),
        .COEFF_RESET_B4(RB4),
        .COEFF_RESET_B5(RB5)
    ) dut (
        .user_clk  (user_clk),
        .user_rst_n(user_rst_n),
        .bus       (bus)
    );

    always #5 user_clk = ~user_clk;

    typedef struct packed {
        logic [31:0] word;
        logic [15:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // reference model state
    logic [31:0] rq_m;
    logic [31:0] active_m;
    logic [31:0] run_val;
    logic [15:0] count_m;
    logic        pend_m;
    logic        start_pend;
    int          cyc;
    int          run_start;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void model_init();
        rq_m       = RW;
        active_m   = RW;
        run_val    = RW;
        count_m    = 16'd0;
        pend_m     = 1'b0;
        start_pend = 1'b0;
        run_start  = cyc;
        exp_q.delete();
    endfunction

    // reference model: evaluated on every rising edge
    initial begin
        cyc = 0;
        model_init();
        forever begin
            @(posedge user_clk);
            if (!user_rst_n) begin
                model_init();
            end else begin
                logic [31:0] v;
                int          age;
                v = rq_m;
                if (v != run_val) begin
                    run_val    = v;
                    run_start  = cyc;
                    start_pend = pend_m;
                end
                age = cyc - run_start;
                if (v != active_m) begin
`ifdef FIR_COEFF_FRAME_ALIGN_EN
                    if (age >= S + 1 && bus.frame_sync) begin
`else
                    if (age == S) begin
`endif
                        active_m = v;
                        count_m  = count_m + 16'd1;
                        exp_q.push_back('{word: v, count: count_m});
                    end
                end
                // pending: a differing word is being worked on, or a revert is still settling
                pend_m = (v != active_m) || (start_pend && (age < S));
                rq_m   = bus.reg_data;
            end
            cyc++;
        end
    end

    // monitor: samples on the falling edge, pops the scoreboard on each pulse
    initial begin
        forever begin
            @(negedge user_clk);
            if (user_rst_n) begin
                if (bus.coeff_update) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_pulse: got coeff_update=1, required 0 (t=%0t)", $time);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        $display("commit word=%h count=%0d", {bus.coeff_b4, bus.coeff_b5}, bus.update_count);
                        check("commit_word", {bus.coeff_b4, bus.coeff_b5}, e.word);
                        check("commit_count", {16'd0, bus.update_count}, {16'd0, e.count});
                    end
                end else if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    compared++;
                    mismatched++;
                    $display("FAIL missing_pulse: got coeff_update=0, required 1 for word %h (t=%0t)", e.word, $time);
                end
                check("active_coeff", {bus.coeff_b4, bus.coeff_b5}, active_m);
                check("update_count", {16'd0, bus.update_count}, {16'd0, count_m});
                check("update_pending", {31'd0, bus.update_pending}, {31'd0, pend_m});
            end
        end
    end

    task automatic step(input logic [31:0] w, input logic fs);
        @(negedge user_clk);
        #1;
        bus.reg_data   = w;
        bus.frame_sync = fs;
    endtask

    // hold a word for n cycles; frame_sync every 'period' cycles (0 = never)
    task automatic hold(input logic [31:0] w, input int n, input int period);
        for (int i = 0; i < n; i++)
            step(w, (period != 0) && ((i % period) == period - 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_b4"}, {16'd0, bus.coeff_b4}, {16'd0, RB4});
        check({tag, "_b5"}, {16'd0, bus.coeff_b5}, {16'd0, RB5});
        check({tag, "_update"}, {31'd0, bus.coeff_update}, 32'd0);
        check({tag, "_pending"}, {31'd0, bus.update_pending}, 32'd0);
        check({tag, "_count"}, {16'd0, bus.update_count}, 32'd0);
    endtask

    initial begin
        logic [31:0] last_w;
        logic [31:0] w;
        bus.reg_data   = RW;
        bus.frame_sync = 1'b0;
        repeat (3) @(negedge user_clk);
        #1;
        check_reset_outputs("reset");
        user_rst_n = 1'b1;

        // reset word held: nothing should happen even with frame pulses
        hold(RW, 12, 3);

        // single write, frame pulse arriving late
        hold(32'h12345678, 9, 0);
        hold(32'h12345678, 1, 1);
        hold(32'h12345678, 6, 0);

        // torn write: only the second value may commit
        hold(32'hAAAA0000, 2, 0);
        hold(32'hAAAA5555, 30, 8);

        // change coinciding with frame_sync while pending: change wins
        hold(32'h0BADF00D, S + 3, 0);
        step(32'h600DCAFE, 1'b0);
        step(32'h600DCAFE, 1'b1);
        hold(32'h600DCAFE, 12, 0);
        hold(32'h600DCAFE, 10, 5);

        // quick excursion and revert: no commit
        hold(32'h00010002, 14, 4);
        hold(32'h00030004, 2, 0);
        hold(32'h00010002, 14, 4);

        // update_count wrap 0xFFFF -> 0x0000
        @(negedge user_clk);
        #1;
        force dut.update_count_reg = 16'hFFFF;
        count_m = 16'hFFFF;
        @(negedge user_clk);
        #1;
        release dut.update_count_reg;
        hold(32'h7FFF8000, 16, 4);

        // reset while a word is settled and waiting
        hold(32'h5A5AA5A5, S + 3, 0);
        @(negedge user_clk);
        #1;
        user_rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        bus.reg_data = RW;
        repeat (2) @(negedge user_clk);
        #1;
        user_rst_n = 1'b1;
        hold(RW, 4, 2);

        // randomized traffic
        last_w = RW;
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 3))
                0:       w = RW;
                1:       w = last_w;
                default: w = $urandom;
            endcase
            last_w = w;
            for (int i = 0; i < int'($urandom_range(1, 14)); i++)
                step(w, ($urandom_range(0, 4) == 0));
        end

        // drain
        hold(last_w, 20, 3);
        hold(last_w, 4, 0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
